// File: rtl/bcd_down_counter_pkg.sv
// bcd_down_counter_pkg: shared state encoding, BCD constants and digit sanitiser.
package bcd_down_counter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  function automatic logic [3:0] bcd_sanitise(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: control and count signals of the BCD countdown timer.
interface bcd_down_counter_if #(parameter int DIGITS = 2);
  logic                  load;
  logic                  enable;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   number;
  logic                  zero;
  logic                  done;
  logic                  busy;
  modport master (output load, enable, load_value, input number, zero, done, busy);
  modport slave (input load, enable, load_value, output number, zero, done, busy);
endinterface

// File: rtl/bcd_down_counter_digit_down.sv
// bcd_digit_down: one BCD digit register that loads a sanitised value or borrows down.
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);
  always_ff @(posedge clk or negedge clear)
    if (!clear) digit <= BCD_ZERO;
    else if (load) digit <= bcd_sanitise(load_digit);
    else if (borrow_in) digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
  assign borrow_out = borrow_in & (digit == BCD_ZERO);
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: multi-digit BCD countdown timer with one-cycle expiry pulse.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic               clk,
  input  logic               clear,
  bcd_down_counter_if.slave  bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);
  state_t             state, state_next;
  logic [W-1:0]       num;
  logic [DIGITS-1:0]  borrow;
  logic               borrow_unused;
  assign borrow[0] = (state == RUN) && bus.enable && !bus.load;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i < DIGITS - 1) begin : g_mid
      bcd_digit_down u_digit (
        .clk        (clk),
        .clear      (clear),
        .load       (bus.load),
        .load_digit (bus.load_value[4*i +: 4]),
        .borrow_in  (borrow[i]),
        .digit      (num[4*i +: 4]),
        .borrow_out (borrow[i+1])
      );
    end else begin : g_top
      bcd_digit_down u_digit (
        .clk        (clk),
        .clear      (clear),
        .load       (bus.load),
        .load_digit (bus.load_value[4*i +: 4]),
        .borrow_in  (borrow[i]),
        .digit      (num[4*i +: 4]),
        .borrow_out (borrow_unused)
      );
    end
  end
  always_ff @(posedge clk or negedge clear)
    if (!clear) state <= IDLE;
    else state <= state_next;
  // Clamping nibbles to 9 never changes zero-ness, so the raw load value decides RUN vs IDLE.
  always_comb begin
    state_next = IDLE;
    if (bus.load) state_next = (|bus.load_value) ? RUN : IDLE;
    else if (state == RUN) state_next = (bus.enable && num == ONE) ? EXPIRED : RUN;
  end
  assign bus.number = num;
  assign bus.zero   = (num == '0);
  assign bus.done   = (state == EXPIRED);
  assign bus.busy   = (state == RUN);
endmodule
